// File: rtl/tdm_demux_16_if.sv
// Bus bundle for the TDM demultiplexer: serial sample input and the parallel output bank.
interface tdm_demux_16_if #(
   parameter int W = 8
);
   logic            in_valid;
   logic            in_sof;
   logic [W-1:0]    in_data;
   logic [16*W-1:0] out_data;
   logic            out_valid;
   logic            frame_err;
   logic            locked;

   modport master (
      output in_valid, in_sof, in_data,
      input  out_data, out_valid, frame_err, locked
   );

   modport slave (
      input  in_valid, in_sof, in_data,
      output out_data, out_valid, frame_err, locked
   );
endinterface

// File: rtl/tdm_demux_16.sv
// 16-channel TDM demultiplexer: fills a shadow bank from a serial stream and
// publishes each complete frame atomically with a one-cycle out_valid strobe.
module tdm_demux_16 #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst,
   tdm_demux_16_if.slave  bus
);
   typedef enum logic {IDLE, RUN} state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [W-1:0]    shadow_q [15];
   logic [16*W-1:0] out_data_q;
   logic            out_valid_q, frame_err_q;
   logic            wr_en, complete, err;
   logic [3:0]      wr_idx;
   logic [16*W-1:0] frame_cat;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wr_en    = 1'b0;
      wr_idx   = cnt_q;
      complete = 1'b0;
      err      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid && bus.in_sof) begin
               wr_en   = 1'b1;
               wr_idx  = '0;
               cnt_d   = 4'd1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (bus.in_valid) begin
               if (bus.in_sof) begin
                  err    = 1'b1;
                  wr_en  = 1'b1;
                  wr_idx = '0;
                  cnt_d  = 4'd1;
               end else if (cnt_q == 4'd15) begin
                  complete = 1'b1;
                  cnt_d    = '0;
                  state_d  = IDLE;
               end else begin
                  wr_en = 1'b1;
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Channel 15 is never stored: the final beat is bypassed straight into the bank.
   always_comb begin
      frame_cat = '0;
      for (int unsigned k = 0; k < 15; k++)
         frame_cat[k*W +: W] = shadow_q[k];
      frame_cat[15*W +: W] = bus.in_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         for (int unsigned k = 0; k < 15; k++)
            shadow_q[k] <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= complete;
         frame_err_q <= err;
         if (wr_en)
            shadow_q[wr_idx] <= bus.in_data;
         if (complete)
            out_data_q <= frame_cat;
      end
   end

   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.frame_err = frame_err_q;
   assign bus.locked    = (state_q == RUN);
endmodule

// File: tb/tb_tdm_demux_16.sv
// Self-checking bench for tdm_demux_16: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based frame model.
module tb_tdm_demux_16;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tdm_demux_16_if #(.W(W)) bus ();

   tdm_demux_16 #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [W-1:0]    frame_q [$];
   logic [16*W-1:0] exp_data  = '0;
   logic            exp_valid = 1'b0;
   logic            exp_err   = 1'b0;
   logic            exp_locked = 1'b0;

   int n_valid = 0;
   int n_err   = 0;

   task automatic check(input string tag, input logic [16*W-1:0] got, input logic [16*W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input logic r, input logic v, input logic s, input logic [W-1:0] d);
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      if (r) begin
         frame_q.delete();
         exp_data = '0;
      end else if (v) begin
         if (s) begin
            if (frame_q.size() > 0) exp_err = 1'b1;
            frame_q.delete();
            frame_q.push_back(d);
         end else if (frame_q.size() > 0) begin
            frame_q.push_back(d);
            if (frame_q.size() == 16) begin
               for (int k = 0; k < 16; k++) exp_data[k*W +: W] = frame_q[k];
               exp_valid = 1'b1;
               frame_q.delete();
            end
         end
      end
      exp_locked = (frame_q.size() > 0);
   endtask

   // One clock cycle: drive inputs, step model at the edge, compare 1 ns later.
   task automatic beat(input logic r, input logic v, input logic s, input logic [W-1:0] d);
      rst          = r;
      bus.in_valid = v;
      bus.in_sof   = s;
      bus.in_data  = d;
      @(posedge clk);
      model_step(r, v, s, d);
      #1;
      check("out_data",  bus.out_data,  exp_data);
      check("out_valid", {127'b0, bus.out_valid}, {127'b0, exp_valid});
      check("frame_err", {127'b0, bus.frame_err}, {127'b0, exp_err});
      check("locked",    {127'b0, bus.locked},    {127'b0, exp_locked});
      if (bus.out_valid) n_valid++;
      if (bus.frame_err) n_err++;
   endtask

   task automatic send_frame(input logic [W-1:0] base, input int gap);
      for (int k = 0; k < 16; k++) begin
         beat(1'b0, 1'b1, (k == 0), base + W'(k));
         for (int g = 0; g < gap; g++) beat(1'b0, 1'b0, 1'b0, W'($urandom));
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0, W'($urandom));
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
      bus.in_data  = '0;

      // reset with random inputs
      for (int i = 0; i < 2; i++) beat(1'b1, 1'($urandom), 1'($urandom), W'($urandom));
      idle(1);

      // single frame, no gaps
      n_valid = 0;
      send_frame(8'h10, 0);
      idle(2);
      check("single_pulses", 128'(n_valid), 128'd1);

      // pre-sync junk then gapped frame
      n_valid = 0;
      for (int i = 0; i < 3; i++) beat(1'b0, 1'b1, 1'b0, 8'hEE);
      send_frame(8'h00, 2);
      idle(2);
      check("gap_pulses", 128'(n_valid), 128'd1);

      // early SOF
      n_valid = 0; n_err = 0;
      for (int k = 0; k < 6; k++) beat(1'b0, 1'b1, (k == 0), 8'hA0 + 8'(k));
      send_frame(8'hB0, 0);
      idle(2);
      check("early_err_pulses", 128'(n_err), 128'd1);
      check("early_valid_pulses", 128'(n_valid), 128'd1);

      // back-to-back frames
      n_valid = 0;
      send_frame(8'h20, 0);
      send_frame(8'h40, 0);
      idle(2);
      check("b2b_pulses", 128'(n_valid), 128'd2);

      // reset mid-frame
      n_valid = 0; n_err = 0;
      for (int k = 0; k < 9; k++) beat(1'b0, 1'b1, (k == 0), 8'h50 + 8'(k));
      beat(1'b1, 1'b1, 1'b0, 8'h59);
      send_frame(8'h60, 0);
      idle(2);
      check("rst_mid_pulses", 128'(n_valid), 128'd1);
      check("rst_mid_err", 128'(n_err), 128'd0);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         logic r, v, s;
         r = ($urandom_range(0, 499) == 0);
         v = ($urandom_range(0, 3) != 0);
         s = ($urandom_range(0, 19) == 0);
         beat(r, v, s, W'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
